bcd_seq_converter: RTL and testbench

//   Sequential binary-to-BCD converter with 7-segment outputs. Uses shift-add-3 (double-dabble), one bit per clock.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_seq_converter_disp.sv | 28 ++
 rtl/bcd_seq_converter.sv | 136 +++++++++++++
 tb/tb_bcd_seq_converter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constant helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   function automatic logic [31:0] pow10(input int unsigned n);
      logic [31:0] r;
      r = 32'd1;
      for (int unsigned i = 0; i < n; i++) r = r * 32'd10;
      return r;
   endfunction

   // All-segments-off pattern for the given display polarity.
   function automatic logic [6:0] seg_blank(input bit active_low);
      return active_low ? '1 : '0;
   endfunction

endpackage

// File: rtl/bcd_seq_converter_disp.sv
// 4-bit to 7-segment decoder, active-low segments, bit 0 = a ... bit 6 = g.
module disp (
   input  logic [3:0] i_val,
   output logic [6:0] o_seg
);

   always_comb begin
      case (i_val)
         4'h0:    o_seg = 7'h40;
         4'h1:    o_seg = 7'h79;
         4'h2:    o_seg = 7'h24;
         4'h3:    o_seg = 7'h30;
         4'h4:    o_seg = 7'h19;
         4'h5:    o_seg = 7'h12;
         4'h6:    o_seg = 7'h02;
         4'h7:    o_seg = 7'h78;
         4'h8:    o_seg = 7'h00;
         4'h9:    o_seg = 7'h10;
         4'hA:    o_seg = 7'h08;
         4'hB:    o_seg = 7'h03;
         4'hC:    o_seg = 7'h46;
         4'hD:    o_seg = 7'h21;
         4'hE:    o_seg = 7'h06;
         default: o_seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, with
// overflow saturation, leading-zero blanking and 7-segment outputs.
module bcd_seq_converter
   import bcd_pkg::*;
#(
   parameter int unsigned W              = 17,
   parameter int unsigned DIGITS         = 6,
   parameter bit          LZ_BLANK       = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [W-1:0]          bin,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int unsigned       BW        = 4 * DIGITS;
   localparam int unsigned       CW        = $clog2(W + 1);
   localparam logic [31:0]       LIMIT     = pow10(DIGITS);
   localparam logic [BW-1:0]     ALL9      = {DIGITS{4'h9}};
   localparam logic [6:0]        SEG_BLANK = seg_blank(SEG_ACTIVE_LOW);

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   state_t            r_state;
   state_t            w_next;
   logic [W-1:0]      r_bin_sr;
   logic [BW-1:0]     r_scratch;
   logic [CW-1:0]     r_cnt;
   logic              r_ovf_pend;
   logic              r_done;
   logic              r_ovf;
   logic [BW-1:0]     r_bcd;

   logic              w_load;
   logic              w_shift_en;
   logic              w_commit;
   logic [31:0]       w_bin32;
   logic              w_ovf_in;
   logic [BW-1:0]     w_adj;
   logic [BW+W-1:0]   w_cat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_SHIFT;
         S_SHIFT: if (r_cnt == CW'(1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (r_state != S_IDLE);
      w_load     = (r_state == S_IDLE) && start;
      w_shift_en = (r_state == S_SHIFT);
      w_commit   = (r_state == S_DONE);
   end

   // Overflow is decided on the captured input, so truncated scratch bits never matter.
   assign w_bin32  = 32'(bin);
   assign w_ovf_in = (w_bin32 >= LIMIT);

   always_comb begin
      w_adj = '0;
      for (int unsigned d = 0; d < DIGITS; d++) w_adj[4*d +: 4] = add3(r_scratch[4*d +: 4]);
   end

   assign w_cat = {w_adj, r_bin_sr} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin_sr   <= '0;
         r_scratch  <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         r_bcd      <= '0;
      end else begin
         r_done <= w_commit;
         if (w_load) begin
            r_bin_sr   <= bin;
            r_scratch  <= '0;
            r_cnt      <= CW'(W);
            r_ovf_pend <= w_ovf_in;
         end else if (w_shift_en) begin
            r_scratch <= w_cat[BW+W-1:W];
            r_bin_sr  <= w_cat[W-1:0];
            r_cnt     <= r_cnt - CW'(1);
         end
         if (w_commit) begin
            r_ovf <= r_ovf_pend;
            r_bcd <= r_ovf_pend ? ALL9 : r_scratch;
         end
      end
   end

   assign done = r_done;
   assign ovf  = r_ovf;
   assign bcd  = r_bcd;

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic [6:0] w_raw;
      logic [6:0] w_pol;
      logic       w_blank;

      disp u_disp (
         .i_val (r_bcd[4*k +: 4]),
         .o_seg (w_raw)
      );

      assign w_pol = SEG_ACTIVE_LOW ? w_raw : ~w_raw;

      if (k == 0) begin : g_lsd
         assign w_blank = 1'b0;
      end else begin : g_upper
         assign w_blank = LZ_BLANK && (r_bcd[BW-1:4*k] == '0) && !r_ovf;
      end

      assign seg[7*k +: 7] = w_blank ? SEG_BLANK : w_pol;
   end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench: three converter variants share stimulus; monitors pop expected results on done.
module tb_bcd_seq_converter;

   typedef struct {
      logic [23:0] bcd;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [16:0] bin;

   logic        d6_busy, d6_done, d6_ovf;
   logic [23:0] d6_bcd;
   logic [41:0] d6_seg;
   logic        d5_busy, d5_done, d5_ovf;
   logic [19:0] d5_bcd;
   logic [34:0] d5_seg;
   logic        dn_busy, dn_done, dn_ovf;
   logic [23:0] dn_bcd;
   logic [41:0] dn_seg;

   exp_t q6[$];
   exp_t q5[$];
   exp_t qn[$];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bcd_seq_converter u_d6 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(d6_busy), .done(d6_done), .ovf(d6_ovf), .bcd(d6_bcd), .seg(d6_seg)
   );

   bcd_seq_converter #(.DIGITS(5)) u_d5 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(d5_busy), .done(d5_done), .ovf(d5_ovf), .bcd(d5_bcd), .seg(d5_seg)
   );

   bcd_seq_converter #(.LZ_BLANK(1'b0)) u_dn (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(dn_busy), .done(dn_done), .ovf(dn_ovf), .bcd(dn_bcd), .seg(dn_seg)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: got event expected none", name);
   endtask

   function automatic logic [6:0] seg_al(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [41:0] seg_model(input logic [23:0] b, input logic o,
                                             input int unsigned nd, input bit lz);
      logic [41:0] r;
      logic        z;
      int unsigned k;
      r = '0;
      z = 1'b1;
      for (int unsigned i = 0; i < nd; i++) begin
         k = nd - 1 - i;
         z = z && (b[4*k +: 4] == 4'd0);
         r[7*k +: 7] = (lz && z && !o && k != 0) ? 7'h7F : seg_al(b[4*k +: 4]);
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (d6_done) begin
         if (q6.size() == 0) fail_now("d6 unexpected done");
         else begin
            exp_t e;
            e = q6.pop_front();
            chk("d6 bcd", d6_bcd, e.bcd);
            chk("d6 ovf", d6_ovf, e.ovf);
            chk("d6 seg", d6_seg, seg_model(e.bcd, e.ovf, 6, 1'b1));
         end
      end
   end

   always @(negedge clk) begin
      if (d5_done) begin
         if (q5.size() == 0) fail_now("d5 unexpected done");
         else begin
            exp_t        e;
            logic [41:0] m;
            e = q5.pop_front();
            m = seg_model(e.bcd, e.ovf, 5, 1'b1);
            chk("d5 bcd", d5_bcd, e.bcd[19:0]);
            chk("d5 ovf", d5_ovf, e.ovf);
            chk("d5 seg", d5_seg, m[34:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (dn_done) begin
         if (qn.size() == 0) fail_now("dn unexpected done");
         else begin
            exp_t e;
            e = qn.pop_front();
            chk("dn bcd", dn_bcd, e.bcd);
            chk("dn ovf", dn_ovf, e.ovf);
            chk("dn seg", dn_seg, seg_model(e.bcd, e.ovf, 6, 1'b0));
         end
      end
   end

   task automatic push(input logic [23:0] e6, input logic o6, input logic [19:0] e5, input logic o5);
      exp_t a;
      exp_t b;
      a.bcd = e6;
      a.ovf = o6;
      b.bcd = {4'h0, e5};
      b.ovf = o5;
      q6.push_back(a);
      qn.push_back(a);
      q5.push_back(b);
   endtask

   // Issue one conversion and wait (bounded) for done; optionally poke start while in DONE.
   task automatic run(input logic [16:0] b, input logic [23:0] e6, input logic o6,
                      input logic [19:0] e5, input logic o5, input bit poke);
      int n;
      push(e6, o6, e5, o5);
      @(negedge clk);
      bin   = b;
      start = 1'b1;
      @(posedge clk);
      n = 0;
      @(negedge clk);
      start = 1'b0;
      while (!d6_done && n < 40) begin
         if (poke && n == 17) begin
            chk("busy in DONE", d6_busy, 1'b1);
            start = 1'b1;
            bin   = 17'd99;
         end
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("done latency", n, 18);
      chk("busy low at done", d6_busy, 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " busy"}, {d6_busy, d5_busy, dn_busy}, 3'b000);
      chk({tag, " done"}, {d6_done, d5_done, dn_done}, 3'b000);
      chk({tag, " ovf"},  {d6_ovf, d5_ovf, dn_ovf}, 3'b000);
      chk({tag, " bcd"},  {d6_bcd, d5_bcd, dn_bcd}, 68'd0);
      chk({tag, " d6 seg"}, d6_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      chk({tag, " d5 seg"}, d5_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      chk({tag, " dn seg"}, dn_seg, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      bin   = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run(17'd0,      24'h000000, 1'b0, 20'h00000, 1'b0, 1'b0);
      chk("zero d6 seg", d6_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
      run(17'd131071, 24'h131071, 1'b0, 20'h99999, 1'b1, 1'b0);
      run(17'd42,     24'h000042, 1'b0, 20'h00042, 1'b0, 1'b0);
      chk("42 d6 seg", d6_seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
      chk("42 dn seg", dn_seg, {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24});
      run(17'd99999,  24'h099999, 1'b0, 20'h99999, 1'b0, 1'b0);
      run(17'd100000, 24'h100000, 1'b0, 20'h99999, 1'b1, 1'b0);

      // start held for three cycles while bin changes: one result for the captured 7
      push(24'h000007, 1'b0, 20'h00007, 1'b0);
      @(negedge clk);
      bin   = 17'd7;
      start = 1'b1;
      @(negedge clk);
      bin   = 17'd9;
      repeat (2) @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      chk("held start idle", d6_busy, 1'b0);

      run(17'd300, 24'h000300, 1'b0, 20'h00300, 1'b0, 1'b1);
      repeat (25) @(negedge clk);
      chk("poke ignored idle", d6_busy, 1'b0);
      chk("poke kept bcd", d6_bcd, 24'h000300);

      run(17'd5000, 24'h005000, 1'b0, 20'h05000, 1'b0, 1'b0);
      chk("5000 held bcd", d6_bcd, 24'h005000);

      // abort a conversion of 1234 with an asynchronous reset eight cycles in
      @(negedge clk);
      bin   = 17'd1234;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("busy before abort", d6_busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("after abort idle", d6_busy, 1'b0);

      run(17'd1234, 24'h001234, 1'b0, 20'h01234, 1'b0, 1'b0);

      repeat (30) @(negedge clk);
      chk("q6 drained", q6.size(), 0);
      chk("q5 drained", q5.size(), 0);
      chk("qn drained", qn.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
